// File: rtl/imem_loader_pkg.sv
// Shared CPU constants for the instruction-memory loader: word/address widths,
// default memory depth and the loader state encoding.
package imem_loader_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    WRITE  = 3'd5,
    CHK    = 3'd6,
    DONE   = 3'd7
  } ld_state_t;

endpackage

// File: rtl/imem_loader_ctrl.sv
// Loader sequencing FSM: walks count, data and checksum phases of the byte stream.
// Latency: one state per accepted byte plus one WRITE cycle per word; stalls indefinitely on byte_valid low.
module imem_loader_ctrl
  import imem_loader_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      byte_valid,
  input  logic      n_zero,
  input  logic      n_over,
  input  logic      last_word,
  output ld_state_t state,
  output logic      byte_ready
);

  ld_state_t state_q;
  ld_state_t state_d;
  logic      xfer;

  assign state      = state_q;
  assign byte_ready = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                      (state_q == DAT_HI) || (state_q == DAT_LO) ||
                      (state_q == CHK);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = CNT_HI;
      CNT_HI:     if (xfer) state_d = CNT_LO;
      CNT_LO: begin
        // Oversized count aborts before any write reaches memory.
        if (xfer) begin
          if (n_over)      state_d = DONE;
          else if (n_zero) state_d = CHK;
          else             state_d = DAT_HI;
        end
      end
      DAT_HI:     if (xfer) state_d = DAT_LO;
      DAT_LO:     if (xfer) state_d = WRITE;
      WRITE:      state_d = last_word ? CHK : DAT_HI;
      CHK:        if (xfer) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a count-prefixed, XOR-checksummed byte image into instruction memory, holding the CPU meanwhile.
// Latency: >= 3 cycles per word (hi, lo, write); backpressure via byte_ready, low outside byte-accepting states.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              len_err,
  output logic              chk_err
);

  ld_state_t         state;
  logic              xfer;
  logic              load;
  logic [7:0]        hi_q;
  logic [7:0]        xor_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] idx_q;
  logic [15:0]       n_in;
  logic              n_zero;
  logic              n_over;
  logic              last_word;

  imem_loader_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .n_zero     (n_zero),
    .n_over     (n_over),
    .last_word  (last_word),
    .state      (state),
    .byte_ready (byte_ready)
  );

  assign xfer      = byte_valid && byte_ready;
  assign load      = start && ((state == IDLE) || (state == DONE));
  assign n_in      = {hi_q, byte_data};
  assign n_zero    = (n_in == 16'd0);
  assign n_over    = ({1'b0, n_in} > 17'(DEPTH));
  assign last_word = (idx_q == (count_q - ADDR_W'(1)));

  assign wr_en     = (state == WRITE);
  assign cpu_hold  = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      xor_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      len_err <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      if (load) begin
        idx_q   <= '0;
        xor_q   <= '0;
        len_err <= 1'b0;
        chk_err <= 1'b0;
      end
      if (xfer) begin
        case (state)
          CNT_HI: begin
            hi_q  <= byte_data;
            xor_q <= xor_q ^ byte_data;
          end
          CNT_LO: begin
            count_q <= n_in;
            xor_q   <= xor_q ^ byte_data;
            if (n_over) len_err <= 1'b1;
          end
          DAT_HI: begin
            hi_q  <= byte_data;
            xor_q <= xor_q ^ byte_data;
          end
          DAT_LO: begin
            // Write address/data are staged here so they are stable through WRITE and hold afterwards.
            xor_q   <= xor_q ^ byte_data;
            wr_addr <= idx_q;
            wr_data <= {hi_q, byte_data};
          end
          CHK:     chk_err <= (byte_data != xor_q);
          default: ;
        endcase
      end
      if (state == WRITE) idx_q <= idx_q + ADDR_W'(1);
    end
  end

endmodule
